// File: rtl/costas_lock_ctrl.sv
// Acquisition/tracking sequencer for the BPSK Costas loop: windowed |error|
// averaging decides lock, and the loop-filter gains follow the lock state.
module costas_lock_ctrl #(
    parameter int          WIN_LOG2    = 4,
    parameter int          ACQ_KP      = 2,
    parameter int          ACQ_KI      = 8,
    parameter int          TRK_KP      = 6,
    parameter int          TRK_KI      = 12,
    parameter logic [31:0] LOCK_TH     = 32'd1000,
    parameter logic [31:0] UNLOCK_TH   = 32'd4000,
    parameter int          LOCK_CNT    = 3,
    parameter int          UNLOCK_CNT  = 2,
    parameter int          ACQ_MAX_WIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        valid,
    input  logic signed [31:0] phase_error,
    output logic [4:0]  kp_shift,
    output logic [4:0]  ki_shift,
    output logic        loop_clear,
    output logic        locked,
    output logic [1:0]  state,
    output logic [7:0]  reacq_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACQ   = 2'd2,
        TRACK = 2'd3
    } state_t;

    localparam int          AW           = 32 + WIN_LOG2;
    localparam logic [4:0]  ACQ_KP_W     = 5'(ACQ_KP);
    localparam logic [4:0]  ACQ_KI_W     = 5'(ACQ_KI);
    localparam logic [4:0]  TRK_KP_W     = 5'(TRK_KP);
    localparam logic [4:0]  TRK_KI_W     = 5'(TRK_KI);
    localparam logic [15:0] LOCK_CNT_W   = 16'(LOCK_CNT);
    localparam logic [15:0] UNLOCK_CNT_W = 16'(UNLOCK_CNT);
    localparam logic [15:0] ACQ_MAX_W    = 16'(ACQ_MAX_WIN);

    state_t                cur;
    state_t                nxt;
    logic [31:0]           pe_raw;
    logic [31:0]           mag;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         sum;
    logic [31:0]           mean;
    logic [WIN_LOG2-1:0]   win_cnt;
    logic [15:0]           good;
    logic [15:0]           bad;
    logic [15:0]           acq_win;
    logic [15:0]           good_nxt;
    logic [15:0]           bad_nxt;
    logic [15:0]           acq_win_nxt;
    logic                  sample;
    logic                  win_end;
    logic                  reacq_evt;
    logic [4:0]            kp_d;
    logic [4:0]            ki_d;
    logic                  clear_d;
    logic                  locked_d;

    assign state  = cur;
    assign pe_raw = phase_error;

    // -2^31 has no positive twin, so its magnitude saturates to 2^31-1.
    always_comb begin
        if (!pe_raw[31])
            mag = pe_raw;
        else if (pe_raw == 32'h8000_0000)
            mag = 32'h7FFF_FFFF;
        else
            mag = 32'(-pe_raw);
    end

    assign sum         = acc + {{WIN_LOG2{1'b0}}, mag};
    assign mean        = sum[WIN_LOG2 +: 32];
    assign sample      = enable && valid && (cur == ACQ || cur == TRACK);
    assign win_end     = sample && (win_cnt == '1);
    assign good_nxt    = (mean < LOCK_TH)   ? good + 16'd1 : 16'd0;
    assign bad_nxt     = (mean > UNLOCK_TH) ? bad + 16'd1  : 16'd0;
    assign acq_win_nxt = acq_win + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            kp_shift   <= ACQ_KP_W;
            ki_shift   <= ACQ_KI_W;
            loop_clear <= 1'b0;
            locked     <= 1'b0;
            reacq_cnt  <= 8'd0;
        end else begin
            cur        <= nxt;
            kp_shift   <= kp_d;
            ki_shift   <= ki_d;
            loop_clear <= clear_d;
            locked     <= locked_d;
            if (reacq_evt && reacq_cnt != 8'hFF)
                reacq_cnt <= reacq_cnt + 8'd1;
        end
    end

    // Lock is checked before timeout so a window that does both locks.
    always_comb begin
        nxt       = cur;
        reacq_evt = 1'b0;
        if (!enable) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE:  nxt = CLEAR;
                CLEAR: nxt = ACQ;
                ACQ: begin
                    if (win_end) begin
                        if (good_nxt >= LOCK_CNT_W) begin
                            nxt = TRACK;
                        end else if (acq_win_nxt >= ACQ_MAX_W) begin
                            nxt       = CLEAR;
                            reacq_evt = 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (win_end && bad_nxt >= UNLOCK_CNT_W) begin
                        nxt       = CLEAR;
                        reacq_evt = 1'b1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        kp_d     = (nxt == TRACK) ? TRK_KP_W : ACQ_KP_W;
        ki_d     = (nxt == TRACK) ? TRK_KI_W : ACQ_KI_W;
        clear_d  = (nxt == CLEAR);
        locked_d = (nxt == TRACK);
    end

    // Entering IDLE or CLEAR wipes every window/streak/timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            win_cnt <= '0;
            good    <= 16'd0;
            bad     <= 16'd0;
            acq_win <= 16'd0;
        end else if (nxt == IDLE || nxt == CLEAR) begin
            acc     <= '0;
            win_cnt <= '0;
            good    <= 16'd0;
            bad     <= 16'd0;
            acq_win <= 16'd0;
        end else if (sample) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
                acc <= '0;
                if (cur == ACQ) begin
                    good    <= good_nxt;
                    acq_win <= acq_win_nxt;
                end else begin
                    bad <= bad_nxt;
                end
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed bench for costas_lock_ctrl: acquisition, lock, unlock, hysteresis,
// enable drop, reset mid-window, lock-vs-timeout priority and reacq saturation.
module tb_costas_lock_ctrl;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              valid;
    logic signed [31:0] phase_error;
    logic [4:0]        kp_shift;
    logic [4:0]        ki_shift;
    logic              loop_clear;
    logic              locked;
    logic [1:0]        state;
    logic [7:0]        reacq_cnt;

    int total = 0;
    int bad   = 0;

    costas_lock_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .valid       (valid),
        .phase_error (phase_error),
        .kp_shift    (kp_shift),
        .ki_shift    (ki_shift),
        .loop_clear  (loop_clear),
        .locked      (locked),
        .state       (state),
        .reacq_cnt   (reacq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic v, input logic signed [31:0] e);
        valid       = v;
        phase_error = e;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input logic signed [31:0] e);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, e);
    endtask

    task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the expected state: gains/locked from TRACK, clear from CLEAR.
    task automatic check_output(input string tag, input logic [1:0] exp_state, input logic [7:0] exp_reacq);
        check_field({tag, ".state"},      32'(state),      32'(exp_state));
        check_field({tag, ".locked"},     32'(locked),     32'(exp_state == 2'd3));
        check_field({tag, ".loop_clear"}, 32'(loop_clear), 32'(exp_state == 2'd1));
        check_field({tag, ".kp"},         32'(kp_shift),   (exp_state == 2'd3) ? 32'd6 : 32'd2);
        check_field({tag, ".ki"},         32'(ki_shift),   (exp_state == 2'd3) ? 32'd12 : 32'd8);
        check_field({tag, ".reacq"},      32'(reacq_cnt),  32'(exp_reacq));
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        valid       = 1'b0;
        phase_error = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", 2'd0, 8'd0);

        // Start-up: IDLE -> CLEAR -> ACQ, then hold ACQ without samples
        rst_n  = 1'b1;
        enable = 1'b1;
        apply_stimulus(1'b0, 0);
        check_output("startup_clear", 2'd1, 8'd0);
        apply_stimulus(1'b0, 0);
        check_output("startup_acq", 2'd2, 8'd0);
        repeat (20) apply_stimulus(1'b0, 0);
        check_output("acq_hold", 2'd2, 8'd0);

        // Lock after three good windows of alternating +/-500
        for (int i = 0; i < 48; i++) begin
            apply_stimulus(1'b1, (i % 2) ? -32'sd500 : 32'sd500);
            if (i == 46) check_output("lock_s47", 2'd2, 8'd0);
        end
        check_output("lock_s48", 2'd3, 8'd0);

        // Unlock: one 5000 window, then one window of saturated -2^31
        feed(16, 32'sd5000);
        check_output("bad_win1", 2'd3, 8'd0);
        feed(15, 32'sh8000_0000);
        check_output("bad_win2_s31", 2'd3, 8'd0);
        feed(1, 32'sh8000_0000);
        check_output("unlock_clear", 2'd1, 8'd1);
        apply_stimulus(1'b0, 0);
        check_output("unlock_acq", 2'd2, 8'd1);

        // Hysteresis: alternating bad/in-between windows never unlock
        feed(48, 32'sd500);
        check_output("relock", 2'd3, 8'd1);
        for (int w = 0; w < 4; w++) begin
            feed(16, 32'sd5000);
            check_output("hyst_bad", 2'd3, 8'd1);
            feed(16, -32'sd2000);
            check_output("hyst_mid", 2'd3, 8'd1);
        end

        // Enable drop in TRACK forces IDLE, ACQ gains, reacq kept
        enable = 1'b0;
        apply_stimulus(1'b1, 32'sd500);
        check_output("track_disable", 2'd0, 8'd1);

        // Asynchronous reset in the middle of an ACQ window
        enable = 1'b1;
        apply_stimulus(1'b0, 0);
        apply_stimulus(1'b0, 0);
        check_output("pre_reset_acq", 2'd2, 8'd1);
        feed(10, 32'sd100000);
        rst_n = 1'b0;
        #2;
        check_output("async_reset", 2'd0, 8'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 0);
        check_output("rst_clear", 2'd1, 8'd0);
        apply_stimulus(1'b0, 0);
        check_output("rst_acq", 2'd2, 8'd0);

        // Enable drop after two good windows plus 10 samples: lock needs 48 fresh samples
        feed(32, 32'sd500);
        check_output("two_good", 2'd2, 8'd0);
        feed(10, 32'sd500);
        enable = 1'b0;
        apply_stimulus(1'b1, 32'sd500);
        check_output("drop_idle", 2'd0, 8'd0);
        enable = 1'b1;
        apply_stimulus(1'b1, 32'sd500);
        check_output("reen_clear", 2'd1, 8'd0);
        apply_stimulus(1'b1, 32'sd500);
        check_output("reen_acq", 2'd2, 8'd0);
        feed(47, 32'sd500);
        check_output("fresh_s47", 2'd2, 8'd0);
        feed(1, 32'sd500);
        check_output("fresh_s48", 2'd3, 8'd0);

        // Lock on the 8th ACQ window wins over timeout
        enable = 1'b0;
        apply_stimulus(1'b0, 0);
        enable = 1'b1;
        apply_stimulus(1'b0, 0);
        apply_stimulus(1'b0, 0);
        check_output("prio_acq", 2'd2, 8'd0);
        feed(80, 32'sd3000);
        check_output("prio_5bad", 2'd2, 8'd0);
        feed(47, 32'sd500);
        check_output("prio_s127", 2'd2, 8'd0);
        feed(1, 32'sd500);
        check_output("prio_lock", 2'd3, 8'd0);

        // Timeout after 128 valid samples, with valid gaps that must not advance it
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 0);
        apply_stimulus(1'b0, 0);
        check_output("to_acq", 2'd2, 8'd0);
        for (int i = 0; i < 128; i++) begin
            if (i % 8 == 3) apply_stimulus(1'b0, 0);
            apply_stimulus(1'b1, (i % 2) ? -32'sd3000 : 32'sd3000);
            if (i == 126) check_output("to_s127", 2'd2, 8'd0);
        end
        check_output("to_first", 2'd1, 8'd1);
        for (int t = 2; t <= 300; t++) begin
            apply_stimulus(1'b0, 0);
            feed(128, 32'sd3000);
            if (t == 255) check_output("to_255", 2'd1, 8'd255);
        end
        check_output("to_sat", 2'd1, 8'd255);
        apply_stimulus(1'b0, 0);
        check_output("to_sat_acq", 2'd2, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/costas_lock_ctrl.md
Name: costas_lock_ctrl

Overview:
- Acquisition/tracking sequencer for the BPSK carrier-recovery loop.
- Monitors the phase-detector error stream and decides when the loop has locked.
- Switches the loop-filter proportional/integral shift gains between wide acquisition and narrow tracking values.
- Pulses an integrator clear on (re)acquisition and flags lock to downstream demodulation.

Parameters:
- WIN_LOG2, 4: window length is 2^WIN_LOG2 valid samples.
- ACQ_KP, 2: proportional shift during acquisition.
- ACQ_KI, 8: integral shift during acquisition.
- TRK_KP, 6: proportional shift during tracking.
- TRK_KI, 12: integral shift during tracking.
- LOCK_TH, 32'd1000: window mean |error| strictly below this is a "good" window.
- UNLOCK_TH, 32'd4000: window mean |error| strictly above this is a "bad" window.
- LOCK_CNT, 3: consecutive good windows needed to declare lock (≥1).
- UNLOCK_CNT, 2: consecutive bad windows needed to declare loss of lock (≥1).
- ACQ_MAX_WIN, 8: windows allowed in ACQ before forced re-acquisition (≥1).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: run controller; low forces IDLE.
- valid, in, 1: phase_error qualifier.
- phase_error, in, 32 signed: phase-detector output.
- kp_shift, out, 5: proportional gain shift to loop filter.
- ki_shift, out, 5: integral gain shift to loop filter.
- loop_clear, out, 1: one-cycle pulse that reloads the loop-filter integrator.
- locked, out, 1: carrier lock flag.
- state, out, 2: 0=IDLE, 1=CLEAR, 2=ACQ, 3=TRACK.
- reacq_cnt, out, 8: saturating count of re-acquisitions (timeout or unlock).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; kp_shift=ACQ_KP, ki_shift=ACQ_KI; loop_clear=0; locked=0; reacq_cnt=0.
  - All window, streak and timeout counters cleared.
- All outputs are registered and reflect the state entered at the preceding edge.
- Magnitude path:
  - |e| = phase_error if ≥0, else -phase_error.
  - -2^31 saturates to 2^31-1.
  - Accumulate into an unsigned (32+WIN_LOG2)-bit register with no overflow possible.
- Window:
  - Counts valid samples only, in ACQ and TRACK.
  - On the edge accepting the 2^WIN_LOG2-th sample, mean = (acc + |e|) >> WIN_LOG2, computed combinationally; the decision is applied at that same edge.
  - The accumulator restarts at 0 and the window counter wraps.
- State transitions:
  - IDLE: enable=1 -> CLEAR.
  - CLEAR: lasts exactly 1 cycle. loop_clear=1 during it; gains = ACQ values; samples arriving in this cycle are ignored; all counters zeroed. Next state is ACQ.
  - ACQ, gains = ACQ values, locked=0, at each window end:
    - mean<LOCK_TH: good streak +1, else good streak = 0.
    - Good streak reaching LOCK_CNT -> TRACK.
    - Otherwise, the ACQ window count reaching ACQ_MAX_WIN -> CLEAR, reacq_cnt+1.
    - Lock takes priority over timeout on the same window.
  - TRACK, gains = TRK values, locked=1, at each window end:
    - mean>UNLOCK_TH: bad streak +1, else bad streak = 0.
    - Bad streak reaching UNLOCK_CNT -> CLEAR, reacq_cnt+1.
    - Mean between the thresholds resets the bad streak (hysteresis).
- enable=0 in any state:
  - -> IDLE at the next edge; locked drops, gains return to ACQ values.
  - Counters are cleared; reacq_cnt is retained.
  - Re-enable always passes through CLEAR.
- reacq_cnt saturates at 255.
- valid=0 cycles freeze the window (no timeout progress).
- Reset asserted mid-window discards the partial accumulation.

Test Plan:
1. Reset, enable=1, no valid -> state goes IDLE→CLEAR→ACQ on consecutive edges; loop_clear high for exactly 1 cycle; kp=2, ki=8; state holds ACQ indefinitely.
2. ACQ, feed 48 valid samples alternating ±500 -> after the 48th sample state=TRACK, locked=1, kp=6, ki=12, reacq_cnt=0.
3. TRACK, feed 16×(+5000) then 16×(-2147483648) -> after the 32nd sample state=CLEAR, loop_clear pulses, then ACQ, reacq_cnt=1. Confirms the saturated magnitude is treated as bad.
4. TRACK, alternate windows of mean 5000 and mean 2000 for 8 windows -> bad streak never reaches 2; state stays TRACK.
5. ACQ, constant |error|=3000 for 128 samples -> timeout at sample 128: CLEAR, reacq_cnt=1. Repeat 300 timeouts -> reacq_cnt saturates at 255.
6. ACQ with 2 good windows and 10 samples into the third, drop enable for 1 cycle -> IDLE, then CLEAR; lock requires 3 fresh good windows (48 samples) after re-entering ACQ.
